// File: rtl/qfc_lane_mac_requant_if.sv
// Handshake and configuration bundle for the quantized dense-layer lane engine.
interface qfc_lane_mac_requant_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned D_W   = 8,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned LEN_W = 10
);
  logic                   i_start;
  logic [LEN_W-1:0]       i_len;
  logic [D_W-1:0]         i_input_zp;
  logic [D_W-1:0]         i_filter_zp;
  logic [D_W-1:0]         i_output_zp;
  logic [31:0]            i_quant_mult;
  logic [4:0]             i_quant_shift;
  logic                   i_relu_en;
  logic [LANES*ACC_W-1:0] i_bias;
  logic                   i_valid;
  logic                   o_ready;
  logic [D_W-1:0]         i_act;
  logic [LANES*D_W-1:0]   i_w;
  logic                   o_valid;
  logic                   i_ready;
  logic [LANES*D_W-1:0]   o_data;
  logic                   o_busy;

  modport master (
    output i_start, i_len, i_input_zp, i_filter_zp, i_output_zp, i_quant_mult,
    output i_quant_shift, i_relu_en, i_bias, i_valid, i_act, i_w, i_ready,
    input  o_ready, o_valid, o_data, o_busy
  );

  modport slave (
    input  i_start, i_len, i_input_zp, i_filter_zp, i_output_zp, i_quant_mult,
    input  i_quant_shift, i_relu_en, i_bias, i_valid, i_act, i_w, i_ready,
    output o_ready, o_valid, o_data, o_busy
  );
endinterface

// File: rtl/qfc_lane_mac_requant.sv
// Multi-lane int8 dense engine: zero-point MAC, bias, optional ReLU, fixed-point requantization.
// Define QFC_SAT_EN to clamp outputs to the int8 range instead of truncating.
module qfc_lane_mac_requant #(
  parameter int unsigned LANES = 4,
  parameter int unsigned D_W   = 8,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned LEN_W = 10
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  qfc_lane_mac_requant_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StAcc, StBias, StMul, StShift, StOut} state_e;

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        len_q, cnt_q;
  logic [D_W-1:0]          in_zp_q, flt_zp_q, out_zp_q;
  logic signed [31:0]      mult_q;
  logic [4:0]              shift_q;
  logic                    relu_q;
  logic signed [ACC_W-1:0] bias_q [LANES];
  logic signed [ACC_W-1:0] acc_q  [LANES];
  logic signed [ACC_W-1:0] acc_d  [LANES];
  logic signed [63:0]      prod_q [LANES];
  logic signed [63:0]      prod_d [LANES];
  logic [LANES*D_W-1:0]    data_q, data_d;
  logic                    beat;
  logic [5:0]              total_shift;

  function automatic logic signed [ACC_W-1:0] mac_term(input logic [D_W-1:0] a,
                                                       input logic [D_W-1:0] w,
                                                       input logic [D_W-1:0] azp,
                                                       input logic [D_W-1:0] wzp);
    logic signed [D_W:0]     da, dw;
    logic signed [2*D_W+1:0] p;
    logic signed [ACC_W-1:0] r;
    da = $signed({a[D_W-1], a}) - $signed({azp[D_W-1], azp});
    dw = $signed({w[D_W-1], w}) - $signed({wzp[D_W-1], wzp});
    p  = da * dw;
    r  = p;
    return r;
  endfunction

  function automatic logic [D_W-1:0] requant(input logic signed [63:0] p,
                                             input logic [5:0]         ts,
                                             input logic [D_W-1:0]     zp);
    logic signed [63:0] rnd, s, z;
    rnd = (ts == 6'd0) ? 64'sd0 : (64'sd1 <<< (ts - 6'd1));
    s   = (p + rnd) >>> ts;
    z   = {{(64-D_W){zp[D_W-1]}}, zp};
    s   = s + z;
`ifdef QFC_SAT_EN
    if (s > ((64'sd1 <<< (D_W-1)) - 64'sd1)) s = (64'sd1 <<< (D_W-1)) - 64'sd1;
    else if (s < -(64'sd1 <<< (D_W-1)))      s = -(64'sd1 <<< (D_W-1));
`endif
    return s[D_W-1:0];
  endfunction

  assign beat        = (state_q == StAcc) && bus.i_valid;
  assign total_shift = 6'd31 - {1'b0, shift_q};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.i_start) state_d = (bus.i_len == '0) ? StBias : StAcc;
      StAcc:   if (beat && (cnt_q == len_q - LEN_W'(1))) state_d = StBias;
      StBias:  state_d = StMul;
      StMul:   state_d = StShift;
      StShift: state_d = StOut;
      StOut:   if (bus.i_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_d = data_q;
    for (int k = 0; k < LANES; k++) begin
      acc_d[k]  = acc_q[k];
      prod_d[k] = 64'(acc_q[k]) * 64'(mult_q);
      unique case (state_q)
        StIdle: if (bus.i_start) acc_d[k] = '0;
        StAcc: begin
          if (beat) begin
            acc_d[k] = acc_q[k] + mac_term(bus.i_act, bus.i_w[k*D_W +: D_W], in_zp_q, flt_zp_q);
          end
        end
        StBias: begin
          acc_d[k] = acc_q[k] + bias_q[k];
          if (relu_q && acc_d[k][ACC_W-1]) acc_d[k] = '0;
        end
        StShift: data_d[k*D_W +: D_W] = requant(prod_q[k], total_shift, out_zp_q);
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      len_q    <= '0;
      cnt_q    <= '0;
      in_zp_q  <= '0;
      flt_zp_q <= '0;
      out_zp_q <= '0;
      mult_q   <= '0;
      shift_q  <= '0;
      relu_q   <= 1'b0;
      data_q   <= '0;
      for (int k = 0; k < LANES; k++) begin
        bias_q[k] <= '0;
        acc_q[k]  <= '0;
        prod_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      for (int k = 0; k < LANES; k++) begin
        acc_q[k] <= acc_d[k];
        if (state_q == StMul) prod_q[k] <= prod_d[k];
      end
      if ((state_q == StIdle) && bus.i_start) begin
        len_q    <= bus.i_len;
        cnt_q    <= '0;
        in_zp_q  <= bus.i_input_zp;
        flt_zp_q <= bus.i_filter_zp;
        out_zp_q <= bus.i_output_zp;
        mult_q   <= bus.i_quant_mult;
        shift_q  <= bus.i_quant_shift;
        relu_q   <= bus.i_relu_en;
        for (int k = 0; k < LANES; k++) bias_q[k] <= bus.i_bias[k*ACC_W +: ACC_W];
      end else if (beat) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
    end
  end

  assign bus.o_ready = (state_q == StAcc);
  assign bus.o_valid = (state_q == StOut);
  assign bus.o_busy  = (state_q != StIdle);
  assign bus.o_data  = data_q;

endmodule
